// File: rtl/aes_256_pkg.sv
// Shared constants, state encoding and inverse-cipher helper functions
// for the AES-256 decryption core.
package aes_256_pkg;

    localparam int BLOCK_SIZE = 128;
    localparam int NR         = 14;
    localparam int UNROLL     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } inv_state_t;

    // Byte x of the inverse S-box sits at [2047-8*x -: 8].
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ gf_xtime(b);
    endfunction

    // State byte i (row i%4, column i/4) lives at [127-8*i -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            r[127 - 32*c      -: 8] = gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3);
            r[127 - 32*c - 8  -: 8] = gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3);
            r[127 - 32*c - 16 -: 8] = gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3);
            r[127 - 32*c - 24 -: 8] = gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_256_inv_roundop.sv
// One combinational inverse round; mix_en low turns it into the final round.
module aes_256_inv_roundop
    import aes_256_pkg::*;
(
    output logic [BLOCK_SIZE-1:0] output_text,
    input  logic [BLOCK_SIZE-1:0] input_text,
    input  logic [BLOCK_SIZE-1:0] round_key,
    input  logic                  mix_en
);

    logic [BLOCK_SIZE-1:0] added;

    always_comb begin
        added       = inv_sub_bytes(inv_shift_rows(input_text)) ^ round_key;
        output_text = mix_en ? inv_mix_columns(added) : added;
    end

endmodule

// File: rtl/aes_256_inv_unroll_7.sv
// AES-256 decryption core: a 7-round inverse chain used twice per block.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | waiting for ciphertext; load applies the round-14 key
//  ST_PASS1 | chain runs rounds 13..7, result back into state_reg
//  ST_PASS2 | chain runs rounds 6..0 (last one without InvMixColumns)
//  ST_DONE  | plaintext held on out_text until the consumer takes it
module aes_256_inv_unroll_7
    import aes_256_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BLOCK_SIZE-1:0]      in_text,
    input  logic [BLOCK_SIZE*15-1:0]   round_keys,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_SIZE-1:0]      out_text,
    output logic                       busy
);

    inv_state_t            state;
    logic [BLOCK_SIZE-1:0] state_reg;
    logic [BLOCK_SIZE-1:0] load_text;
    logic [BLOCK_SIZE-1:0] chain_text [UNROLL+1];
    logic                  pass1;

    assign pass1         = (state == ST_PASS1);
    assign load_text     = in_text ^ round_keys[BLOCK_SIZE*NR +: BLOCK_SIZE];
    assign chain_text[0] = state_reg;
    assign in_ready      = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [BLOCK_SIZE-1:0] key_k;

        assign key_k = pass1 ? round_keys[BLOCK_SIZE*(NR-1-k) +: BLOCK_SIZE]
                             : round_keys[BLOCK_SIZE*(UNROLL-1-k) +: BLOCK_SIZE];

        aes_256_inv_roundop u_op (
            .output_text (chain_text[k+1]),
            .input_text  (chain_text[k]),
            .round_key   (key_k),
            .mix_en      ((k < UNROLL-1) ? 1'b1 : pass1)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            state_reg <= '0;
            out_text  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_reg <= load_text;
                        state     <= ST_PASS1;
                        busy      <= 1'b1;
                    end
                end
                ST_PASS1: begin
                    state_reg <= chain_text[UNROLL];
                    state     <= ST_PASS2;
                end
                ST_PASS2: begin
                    out_text  <= chain_text[UNROLL];
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // A waiting block is taken on the same edge the result leaves.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            state_reg <= load_text;
                            state     <= ST_PASS1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_256_inv_unroll_7.sv
// Directed and model-checked bench for the AES-256 decryption core.
module tb_aes_256_inv_unroll_7;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_text;
    logic [1919:0] round_keys;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_text;
    logic          busy;

    int total;
    int bad;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

    aes_256_inv_unroll_7 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_text    (in_text),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_text   (out_text),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] bget(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [1919:0] key_exp(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [1919:0] rk;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp  = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        rk = '0;
        for (int r = 0; r < 15; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1919:0] rk);
        logic [127:0] s, t, m;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk[127:0];
        for (int r = 1; r <= 14; r++) begin
            t = '0;
            for (int i = 0; i < 16; i++)
                t[127 - 8*i -: 8] = sb[bget(s, 4*(((i/4) + (i%4)) % 4) + (i%4))];
            if (r < 14) begin
                m = '0;
                for (int c = 0; c < 4; c++) begin
                    a0 = bget(t, 4*c); a1 = bget(t, 4*c+1); a2 = bget(t, 4*c+2); a3 = bget(t, 4*c+3);
                    m[127 - 32*c      -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    m[127 - 32*c - 8  -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    m[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    m[127 - 32*c - 24 -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
                t = m;
            end
            s = t ^ rk[128*r +: 128];
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [1919:0] rk);
        logic [127:0] s, t, m;
        logic [7:0]   a0, a1, a2, a3;
        s = ct ^ rk[128*14 +: 128];
        for (int r = 13; r >= 0; r--) begin
            t = '0;
            for (int i = 0; i < 16; i++)
                t[127 - 8*i -: 8] = isb[bget(s, 4*(((i/4) - (i%4) + 4) % 4) + (i%4))];
            t = t ^ rk[128*r +: 128];
            if (r > 0) begin
                m = '0;
                for (int c = 0; c < 4; c++) begin
                    a0 = bget(t, 4*c); a1 = bget(t, 4*c+1); a2 = bget(t, 4*c+2); a3 = bget(t, 4*c+3);
                    m[127 - 32*c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    m[127 - 32*c - 8  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    m[127 - 32*c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    m[127 - 32*c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
                t = m;
            end
            s = t;
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered at the first falling edge after the accept edge, in_valid already dropped.
    task automatic finish_out(input logic [127:0] exp, input string tag);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_val({tag, "_lat"}, 128'(n), 128'd3);
        chk_val({tag, "_text"}, out_text, exp);
        out_ready = 1'b1;
        @(negedge clk);
        chk_val({tag, "_ovdrop"}, 128'(out_valid), 128'd0);
    endtask

    task automatic xfer(input logic [127:0] ct, input logic [1919:0] rk,
                        input logic [127:0] exp, input string tag);
        int n;
        @(negedge clk);
        in_text    = ct;
        round_keys = rk;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_val({tag, "_inrdy"}, 128'(in_ready), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        finish_out(exp, tag);
    endtask

    initial begin
        logic [7:0]    inv, s;
        logic [1919:0] rk_c3, rk;
        logic [127:0]  pt_a, pt_b, ct_a, ct_b;
        logic [127:0]  bt_ct [8];
        logic [127:0]  bt_pt [8];
        int            idx_in, idx_out, last_acc, cyc, n;
        logic          pend;

        total = 0;
        bad   = 0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
                ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
        rk_c3 = key_exp(C3_KEY);

        // Reset values
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_text = '0; round_keys = rk_c3;
        repeat (2) @(negedge clk);
        chk_val("rst_ov", 128'(out_valid), 128'd0);
        chk_val("rst_ot", out_text, 128'd0);
        chk_val("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("rel_ov", 128'(out_valid), 128'd0);
        chk_val("rel_busy", 128'(busy), 128'd0);
        chk_val("rel_inrdy", 128'(in_ready), 128'd1);

        // in_valid held through reset: accepted on first edge after release
        rst_n = 1'b0; in_valid = 1'b1; in_text = C3_CT;
        repeat (2) @(negedge clk);
        chk_val("hold_rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("hold_acc_busy", 128'(busy), 128'd1);
        in_valid = 1'b0;
        finish_out(C3_PT, "hold");

        // FIPS-197 C.3
        xfer(C3_CT, rk_c3, C3_PT, "c3");

        // Backpressure
        rk   = key_exp(rnd256());
        pt_a = rnd128(); pt_b = rnd128();
        ct_a = aes_enc(pt_a, rk); ct_b = aes_enc(pt_b, rk);
        @(negedge clk);
        round_keys = rk; in_text = ct_a; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_val("bp_a_ov", 128'(out_valid), 128'd1);
        in_text = ct_b; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_val("bp_hold_text", out_text, pt_a);
            chk_val("bp_hold_inrdy", 128'(in_ready), 128'd0);
            chk_val("bp_hold_ov", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        #1;
        chk_val("bp_rel_inrdy", 128'(in_ready), 128'd1);
        @(negedge clk);
        chk_val("bp_b_acc_ov", 128'(out_valid), 128'd0);
        chk_val("bp_b_acc_busy", 128'(busy), 128'd1);
        in_valid = 1'b0;
        finish_out(pt_b, "bp_b");

        // Back-to-back
        rk = key_exp(rnd256());
        for (int i = 0; i < 8; i++) begin
            bt_ct[i] = rnd128();
            bt_pt[i] = aes_dec(bt_ct[i], rk);
        end
        @(negedge clk);
        round_keys = rk; in_text = bt_ct[0]; in_valid = 1'b1; out_ready = 1'b1;
        idx_in = 0; idx_out = 0; last_acc = 0; cyc = 0; pend = 1'b0;
        while (idx_out < 8 && cyc < 100) begin
            if (pend) begin
                idx_in++;
                if (idx_in < 8) in_text = bt_ct[idx_in];
                else in_valid = 1'b0;
            end
            pend = in_valid & in_ready;
            if (pend) begin
                if (idx_in > 0) chk_val("b2b_spacing", 128'(cyc - last_acc), 128'd3);
                last_acc = cyc;
            end
            if (out_valid) begin
                chk_val("b2b_text", out_text, bt_pt[idx_out]);
                idx_out++;
            end
            @(negedge clk);
            cyc++;
        end
        chk_val("b2b_count", 128'(idx_out), 128'd8);
        in_valid = 1'b0;
        @(negedge clk);

        // Round trip
        for (int v = 0; v < 1000; v++) begin
            rk   = key_exp(rnd256());
            pt_a = rnd128();
            xfer(aes_enc(pt_a, rk), rk, pt_a, "rt");
        end

        // Reset during PASS2
        @(negedge clk);
        round_keys = rk_c3; in_text = C3_CT; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_val("mid_rst_ov", 128'(out_valid), 128'd0);
        chk_val("mid_rst_ot", out_text, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_val("mid_rel_ov", 128'(out_valid), 128'd0);
        end
        chk_val("mid_rel_ot", out_text, 128'd0);
        chk_val("mid_rel_inrdy", 128'(in_ready), 128'd1);
        chk_val("mid_rel_busy", 128'(busy), 128'd0);
        xfer(C3_CT, rk_c3, C3_PT, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
